// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one external combinational
// W x W multiplier between two requesters. The winning operands are
// registered onto mul_a/mul_b, the product is captured after MUL_LAT settle
// cycles, and it is returned with the owner id on a valid/ready response port.
module mult_share_arbiter #(
    parameter int W       = 3,
    parameter int MUL_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           req1_ready,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [2*W-1:0] mul_p,
    output logic           rsp_valid,
    output logic           rsp_id,
    output logic [2*W-1:0] rsp_p,
    input  logic           rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter preload: a value of 0 captures mul_p on the first WAIT edge.
    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       last_grant;
    logic       grant;
    logic       any_valid;
    logic       xfer;

    // Round-robin grant and the ready strobes; only meaningful in IDLE.
    // NOTE: every signal written in an always_comb gets a default first so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        grant     = 1'b0;
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        req0_ready = (state == IDLE) && any_valid && !grant;
        req1_ready = (state == IDLE) && any_valid &&  grant;
        xfer       = req0_ready | req1_ready;
    end

    // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer)       state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath: operand launch, settle countdown, product capture, response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_p      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        mul_a      <= grant ? req1_a : req0_a;
                        mul_b      <= grant ? req1_b : req0_b;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        cnt        <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_p     <= mul_p;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
